// File: rtl/mul9x9_chk_pkg.sv
// Shared definitions for the MULT9X9 input-registered checker.
// Holds the run-state enum, LFSR taps, operand/product/count widths, the
// bit positions of the stimulus fields inside the LFSR word, the LFSR
// step function and the stimulus field decoder.
package mul9x9_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int OP_W   = 9;
    localparam int PROD_W = 18;
    localparam int CNT_W  = 16;

    // Field positions inside the advanced LFSR value.
    localparam int A_LSB    = 0;
    localparam int B_LSB    = 9;
    localparam int CEA_BIT  = 18;
    localparam int CEB_BIT  = 19;
    localparam int RSTA_LSB = 20;
    localparam int RSTB_LSB = 23;
    localparam int RLD_LSB  = 26;
    localparam int ASGN_BIT = 29;
    localparam int BSGN_BIT = 30;

    typedef struct packed {
        logic            reload;
        logic            cea;
        logic            ceb;
        logic            rsta;
        logic            rstb;
        logic            a_signed;
        logic            b_signed;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } stim_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        lfsr_step = l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    // Bit 31 of the LFSR carries no field, so only [30:0] is decoded.
    // A reload vector forces both CEs and suppresses both resets so the
    // model and the DUT start from the same operands whenever signedness
    // may change.
    function automatic stim_t decode_stim(input logic [30:0] l, input logic first);
        stim_t s;
        s.reload   = (l[RLD_LSB +: 3] == 3'd0) || first;
        s.a        = l[A_LSB +: OP_W];
        s.b        = l[B_LSB +: OP_W];
        s.cea      = l[CEA_BIT] | s.reload;
        s.ceb      = l[CEB_BIT] | s.reload;
        s.rsta     = (l[RSTA_LSB +: 3] == 3'd0) & ~s.reload;
        s.rstb     = (l[RSTB_LSB +: 3] == 3'd0) & ~s.reload;
        s.a_signed = l[ASGN_BIT];
        s.b_signed = l[BSGN_BIT];
        return s;
    endfunction

endpackage

// File: rtl/mul9x9_ireg_checker_if.sv
// Stimulus/response bus between the checker and the MULT9X9 under test.
// master: checker side (drives stimulus, reads z).
// slave : multiplier side (reads stimulus, drives z).
//
// Handshake: strobe is high for exactly one cycle per vector and qualifies
// cea/ceb/rsta/rstb/a/b/a_signed/b_signed in that cycle; there is no
// back-pressure, the multiplier must register on every strobe. Outside the
// strobe cycle all stimulus signals hold. z is combinational from the
// multiplier's input registers and is read STROBE_DIV-1 cycles after strobe.
interface mul9x9_ireg_checker_if;
    import mul9x9_chk_pkg::*;

    logic              strobe;
    logic              cea;
    logic              ceb;
    logic              rsta;
    logic              rstb;
    logic              a_signed;
    logic              b_signed;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] z;

    modport master (
        output strobe, cea, ceb, rsta, rstb, a_signed, b_signed, a, b,
        input  z
    );

    modport slave (
        input  strobe, cea, ceb, rsta, rstb, a_signed, b_signed, a, b,
        output z
    );

endinterface

// File: rtl/mul9x9_ref_model.sv
// Golden model of the input-registered 9x9 multiplier.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : synchronous clear of both operand registers
//   upd             : register update enable (edge ending the strobe cycle)
//   rsta/rstb       : operand register resets, priority over CE
//   cea/ceb         : operand register clock enables
//   a_signed/b_signed: operand signedness, applied combinationally
//   a, b            : operands
//   exp_z           : expected 18-bit product of the registered operands
module mul9x9_ref_model
    import mul9x9_chk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              upd,
    input  logic              rsta,
    input  logic              rstb,
    input  logic              cea,
    input  logic              ceb,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] exp_z
);

    logic [OP_W-1:0]   ma;
    logic [OP_W-1:0]   mb;
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else if (clr) begin
            ma <= '0;
            mb <= '0;
        end else if (upd) begin
            if (rsta)     ma <= '0;
            else if (cea) ma <= a;
            if (rstb)     mb <= '0;
            else if (ceb) mb <= b;
        end
    end

    // The low 18 bits of an 18x18 product are identical for signed and
    // unsigned multiplication, so only the extension depends on signedness.
    always_comb begin
        ea    = a_signed ? {{(PROD_W-OP_W){ma[OP_W-1]}}, ma} : {{(PROD_W-OP_W){1'b0}}, ma};
        eb    = b_signed ? {{(PROD_W-OP_W){mb[OP_W-1]}}, mb} : {{(PROD_W-OP_W){1'b0}}, mb};
        exp_z = ea * eb;
    end

endmodule

// File: rtl/mul9x9_ireg_checker.sv
// Self-checking stimulus/response engine for the MULT9X9 input-registered
// hardware test. An LFSR generates one vector every STROBE_DIV cycles, the
// golden model tracks the multiplier's input registers and z is compared
// at the last phase of every vector.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   start      : one-cycle run request (ignored while busy)
//   busy       : run in progress
//   done       : run finished, held until the next accepted start
//   pass       : valid with done, set when no mismatch occurred
//   err_count  : saturating mismatch count
//   state_dbg  : current run state
//   bus        : stimulus/response bus to the multiplier (master side)
// Optional (MUL9X9_CHECKER_FIRST_FAIL_EN): ff_valid/ff_index/ff_z/ff_exp
//   capture the first mismatch of a run.
module mul9x9_ireg_checker
    import mul9x9_chk_pkg::*;
#(
    parameter int          NUM_VECTORS = 4096,
    parameter int          STROBE_DIV  = 4,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_1234
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output chk_state_e            state_dbg,
`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
    output logic                  ff_valid,
    output logic [CNT_W-1:0]      ff_index,
    output logic [PROD_W-1:0]     ff_z,
    output logic [PROD_W-1:0]     ff_exp,
`endif
    mul9x9_ireg_checker_if.master bus
);

    localparam int              PH_W     = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(STROBE_DIV - 1);
    localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(NUM_VECTORS - 1);
    // An all-zero Galois LFSR would lock up.
    localparam logic [31:0]     SEED_EFF = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

    chk_state_e        state;
    logic [PH_W-1:0]   ph;
    logic [CNT_W-1:0]  vec_idx;
    logic [31:0]       lfsr;

    logic              strobe_q, cea_q, ceb_q, rsta_q, rstb_q, asgn_q, bsgn_q;
    logic [OP_W-1:0]   a_q, b_q;

    logic              in_run, accept, is_cmp, upd, load, mismatch;
    logic [31:0]       lfsr_adv;
    stim_t             nxt;
    logic [PROD_W-1:0] exp_z;
    logic [CNT_W-1:0]  err_nxt;

    assign in_run   = (state == ST_RUN);
    assign accept   = !in_run && start;
    assign is_cmp   = in_run && (ph == PH_LAST);
    assign upd      = in_run && (ph == '0);
    // New stimulus is loaded on the accept edge (vector 0) and on every
    // compare edge except the last one.
    assign load     = accept || (is_cmp && (vec_idx != VEC_LAST));

    // Outside RUN the next advance starts from the seed, so vector 0 is
    // always the first step of a freshly loaded LFSR.
    assign lfsr_adv = lfsr_step(in_run ? lfsr : SEED_EFF);
    assign nxt      = decode_stim(lfsr_adv[30:0], !in_run);

    assign mismatch = is_cmp && (bus.z != exp_z);
    assign err_nxt  = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

    assign state_dbg    = state;
    assign bus.strobe   = strobe_q;
    assign bus.cea      = cea_q;
    assign bus.ceb      = ceb_q;
    assign bus.rsta     = rsta_q;
    assign bus.rstb     = rstb_q;
    assign bus.a_signed = asgn_q;
    assign bus.b_signed = bsgn_q;
    assign bus.a        = a_q;
    assign bus.b        = b_q;

    mul9x9_ref_model u_ref (
        .clk      (clk),
        .rst_n    (rstn),
        .clr      (accept),
        .upd      (upd),
        .rsta     (rsta_q),
        .rstb     (rstb_q),
        .cea      (cea_q),
        .ceb      (ceb_q),
        .a_signed (asgn_q),
        .b_signed (bsgn_q),
        .a        (a_q),
        .b        (b_q),
        .exp_z    (exp_z)
    );

    // Run FSM with phase/vector counters and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            ph        <= '0;
            vec_idx   <= '0;
            lfsr      <= SEED_EFF;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        ph        <= '0;
                        vec_idx   <= '0;
                        lfsr      <= lfsr_adv;
                    end
                end
                ST_RUN: begin
                    err_count <= err_nxt;
                    if (ph == PH_LAST) begin
                        if (vec_idx == VEC_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end else begin
                            ph      <= '0;
                            vec_idx <= vec_idx + 1'b1;
                            lfsr    <= lfsr_adv;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stimulus registers: strobe marks the cycle after a load, everything
    // else holds between loads. Signedness only moves on reload vectors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strobe_q <= 1'b0;
            cea_q    <= 1'b0;
            ceb_q    <= 1'b0;
            rsta_q   <= 1'b0;
            rstb_q   <= 1'b0;
            asgn_q   <= 1'b0;
            bsgn_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            strobe_q <= load;
            if (load) begin
                cea_q  <= nxt.cea;
                ceb_q  <= nxt.ceb;
                rsta_q <= nxt.rsta;
                rstb_q <= nxt.rstb;
                a_q    <= nxt.a;
                b_q    <= nxt.b;
                if (nxt.reload) begin
                    asgn_q <= nxt.a_signed;
                    bsgn_q <= nxt.b_signed;
                end
            end
        end
    end

`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff_valid <= 1'b0;
            ff_index <= '0;
            ff_z     <= '0;
            ff_exp   <= '0;
        end else if (accept) begin
            ff_valid <= 1'b0;
            ff_index <= '0;
            ff_z     <= '0;
            ff_exp   <= '0;
        end else if (mismatch && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_index <= vec_idx;
            ff_z     <= bus.z;
            ff_exp   <= exp_z;
        end
    end
`endif

endmodule

// File: tb/tb_mul9x9_ireg_checker.sv
// Bench for mul9x9_ireg_checker: a behavioural input-registered MULT9X9
// (with selectable faults) answers the checker; directed runs check timing,
// pass/err results, the seed-zero stimulus sequence, reset behaviour and the
// reference model products.
module tb_mul9x9_ireg_checker;
    import mul9x9_chk_pkg::*;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic start_m = 1'b0;
    logic start16 = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 0 = correct multiplier, 1 = z[0] stuck at 0, 2 = CE over reset
    int fault_mode = 0;

    // ------------------------------------------------------------------
    // Main instance: 256 vectors, default seed
    // ------------------------------------------------------------------
    mul9x9_ireg_checker_if bus_m ();
    logic             busy_m, done_m, pass_m;
    logic [15:0]      err_m;
    chk_state_e       st_m;
`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
    logic             ffv_m;
    logic [15:0]      ffi_m;
    logic [17:0]      ffz_m, ffe_m;
`endif

    mul9x9_ireg_checker #(.NUM_VECTORS(256), .STROBE_DIV(4)) u_chk (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start_m),
        .busy      (busy_m),
        .done      (done_m),
        .pass      (pass_m),
        .err_count (err_m),
        .state_dbg (st_m),
`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
        .ff_valid  (ffv_m),
        .ff_index  (ffi_m),
        .ff_z      (ffz_m),
        .ff_exp    (ffe_m),
`endif
        .bus       (bus_m)
    );

    // ------------------------------------------------------------------
    // Small instance: 16 vectors, seed 0 (behaves as seed 1)
    // ------------------------------------------------------------------
    mul9x9_ireg_checker_if bus16 ();
    logic             busy16, done16, pass16;
    logic [15:0]      err16;
    chk_state_e       st16;
`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
    logic             ffv16;
    logic [15:0]      ffi16;
    logic [17:0]      ffz16, ffe16;
`endif

    mul9x9_ireg_checker #(.NUM_VECTORS(16), .STROBE_DIV(4), .LFSR_SEED(32'd0)) u_chk16 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start16),
        .busy      (busy16),
        .done      (done16),
        .pass      (pass16),
        .err_count (err16),
        .state_dbg (st16),
`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
        .ff_valid  (ffv16),
        .ff_index  (ffi16),
        .ff_z      (ffz16),
        .ff_exp    (ffe16),
`endif
        .bus       (bus16)
    );

    // ------------------------------------------------------------------
    // Standalone reference model for directed product checks
    // ------------------------------------------------------------------
    logic       rm_clr = 1'b0, rm_upd = 1'b0;
    logic       rm_rsta = 1'b0, rm_rstb = 1'b0, rm_cea = 1'b0, rm_ceb = 1'b0;
    logic       rm_as = 1'b0, rm_bs = 1'b0;
    logic [8:0] rm_a = '0, rm_b = '0;
    logic [17:0] rm_exp;

    mul9x9_ref_model u_rm (
        .clk      (clk),
        .rst_n    (rstn),
        .clr      (rm_clr),
        .upd      (rm_upd),
        .rsta     (rm_rsta),
        .rstb     (rm_rstb),
        .cea      (rm_cea),
        .ceb      (rm_ceb),
        .a_signed (rm_as),
        .b_signed (rm_bs),
        .a        (rm_a),
        .b        (rm_b),
        .exp_z    (rm_exp)
    );

    // ------------------------------------------------------------------
    // Behavioural multipliers
    // ------------------------------------------------------------------
    function automatic logic [17:0] ref_prod(input logic [8:0] x, input logic [8:0] y,
                                             input logic sx, input logic sy);
        int vx, vy, p;
        vx = int'(x);
        vy = int'(y);
        if (sx && x[8]) vx = vx - 512;
        if (sy && y[8]) vy = vy - 512;
        p = vx * vy;
        return p[17:0];
    endfunction

    logic [8:0]  dut_a, dut_b, shd_a, shd_b;
    logic [17:0] dut_p, p_ok;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dut_a <= '0; dut_b <= '0; shd_a <= '0; shd_b <= '0;
        end else if (bus_m.strobe) begin
            if (fault_mode == 2) begin
                if (bus_m.cea) dut_a <= bus_m.a; else if (bus_m.rsta) dut_a <= '0;
                if (bus_m.ceb) dut_b <= bus_m.b; else if (bus_m.rstb) dut_b <= '0;
            end else begin
                if (bus_m.rsta) dut_a <= '0; else if (bus_m.cea) dut_a <= bus_m.a;
                if (bus_m.rstb) dut_b <= '0; else if (bus_m.ceb) dut_b <= bus_m.b;
            end
            if (bus_m.rsta) shd_a <= '0; else if (bus_m.cea) shd_a <= bus_m.a;
            if (bus_m.rstb) shd_b <= '0; else if (bus_m.ceb) shd_b <= bus_m.b;
        end
    end

    assign dut_p   = ref_prod(dut_a, dut_b, bus_m.a_signed, bus_m.b_signed);
    assign p_ok    = ref_prod(shd_a, shd_b, bus_m.a_signed, bus_m.b_signed);
    assign bus_m.z = (fault_mode == 1) ? {dut_p[17:1], 1'b0} : dut_p;

    logic [8:0] d16_a, d16_b;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d16_a <= '0; d16_b <= '0;
        end else if (bus16.strobe) begin
            if (bus16.rsta) d16_a <= '0; else if (bus16.cea) d16_a <= bus16.a;
            if (bus16.rstb) d16_b <= '0; else if (bus16.ceb) d16_b <= bus16.b;
        end
    end
    assign bus16.z = ref_prod(d16_a, d16_b, bus16.a_signed, bus16.b_signed);

    // Per-vector bookkeeping for the main instance: odd correct products
    // and vectors where the multiplier's answer differs from the correct one.
    logic eval_pending = 1'b0;
    logic cnt_clr = 1'b0;
    int   odd_cnt = 0;
    int   diff_cnt = 0;

    always @(posedge clk) eval_pending <= bus_m.strobe;

    always @(negedge clk) begin
        if (cnt_clr) begin
            odd_cnt  <= 0;
            diff_cnt <= 0;
        end else if (eval_pending) begin
            if (p_ok[0]) odd_cnt <= odd_cnt + 1;
            if (bus_m.z !== p_ok) diff_cnt <= diff_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic pulse_main();
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
    endtask

    task automatic pulse16();
        @(negedge clk) start16 = 1'b1;
        @(negedge clk) start16 = 1'b0;
    endtask

    // Runs the main instance to done; returns cycles from busy rise to done.
    task automatic run_main(input int mode, output int cycles);
        int n;
        fault_mode = mode;
        cnt_clr = 1'b1;
        @(negedge clk);
        #1 cnt_clr = 1'b0;
        pulse_main();
        checks++;
        if (busy_m !== 1'b1 || done_m !== 1'b0) begin
            errors++;
            $display("FAIL run_start busy=%b done=%b required busy=1 done=0", busy_m, done_m);
        end
        n = 0;
        while (done_m !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        cycles = n;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_m, done_m, pass_m, err_m} !== 19'd0) begin
            errors++;
            $display("FAIL reset_status busy=%b done=%b pass=%b err=%0d required all 0",
                     busy_m, done_m, pass_m, err_m);
        end
        checks++;
        if ({bus_m.strobe, bus_m.cea, bus_m.ceb, bus_m.rsta, bus_m.rstb,
             bus_m.a_signed, bus_m.b_signed, bus_m.a, bus_m.b} !== 25'd0) begin
            errors++;
            $display("FAIL reset_bus a=%h b=%h strobe=%b cea=%b required all 0",
                     bus_m.a, bus_m.b, bus_m.strobe, bus_m.cea);
        end
        checks++;
        if (st_m !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d required %0d", st_m, ST_IDLE);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ref_products();
        // signed 0x1FF * signed 0x002 loaded on a forced-reload style vector
        @(negedge clk);
        rm_upd = 1'b1; rm_cea = 1'b1; rm_ceb = 1'b1; rm_rsta = 1'b0; rm_rstb = 1'b0;
        rm_a = 9'h1FF; rm_b = 9'h002; rm_as = 1'b1; rm_bs = 1'b1;
        @(negedge clk);
        rm_upd = 1'b0;
        checks++;
        if (rm_exp !== 18'h3FFFE) begin
            errors++;
            $display("FAIL ref_signed got %h required 3fffe", rm_exp);
        end
        rm_as = 1'b0; rm_bs = 1'b0;
        #1;
        checks++;
        if (rm_exp !== 18'h003FE) begin
            errors++;
            $display("FAIL ref_unsigned got %h required 003fe", rm_exp);
        end
        // reset has priority over CE
        @(negedge clk);
        rm_upd = 1'b1; rm_rsta = 1'b1; rm_cea = 1'b1; rm_ceb = 1'b0; rm_a = 9'h0AB;
        @(negedge clk);
        rm_upd = 1'b0; rm_rsta = 1'b0;
        checks++;
        if (rm_exp !== 18'h00000) begin
            errors++;
            $display("FAIL ref_rst_prio got %h required 00000", rm_exp);
        end
        // CE alone loads; b is still 2 -> 0xAB*2
        @(negedge clk);
        rm_upd = 1'b1; rm_cea = 1'b1; rm_a = 9'h0AB;
        @(negedge clk);
        rm_upd = 1'b0;
        checks++;
        if (rm_exp !== 18'h00156) begin
            errors++;
            $display("FAIL ref_ce_load got %h required 00156", rm_exp);
        end
        // no update: inputs change but registers hold
        rm_a = 9'h001; rm_cea = 1'b1;
        @(negedge clk);
        checks++;
        if (rm_exp !== 18'h00156) begin
            errors++;
            $display("FAIL ref_hold got %h required 00156", rm_exp);
        end
        // synchronous clear
        rm_clr = 1'b1;
        @(negedge clk);
        rm_clr = 1'b0; rm_cea = 1'b0;
        checks++;
        if (rm_exp !== 18'h00000) begin
            errors++;
            $display("FAIL ref_clr got %h required 00000", rm_exp);
        end
    endtask

    // Seed 0 behaves as seed 1: first four advanced LFSR values are
    // 80200003, C0300002, 60180001, B02C0003.
    task automatic test_seed_zero();
        logic [23:0] exp_v [4];
        logic [23:0] got;
        int n;
        // {cea, ceb, rsta, rstb, a_signed, b_signed, a[8:0], b[8:0]}
        exp_v[0] = {6'b110000, 9'h003, 9'h000};
        exp_v[1] = {6'b110001, 9'h002, 9'h000};
        exp_v[2] = {6'b110011, 9'h001, 9'h000};
        exp_v[3] = {6'b110111, 9'h003, 9'h000};
        pulse16();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            got = {bus16.cea, bus16.ceb, bus16.rsta, bus16.rstb,
                   bus16.a_signed, bus16.b_signed, bus16.a, bus16.b};
            checks++;
            if (bus16.strobe !== 1'b1 || got !== exp_v[k]) begin
                errors++;
                $display("FAIL seed0_vec%0d strobe=%b got %h required strobe=1 %h",
                         k, bus16.strobe, got, exp_v[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus16.strobe !== 1'b0) begin
            errors++;
            $display("FAIL seed0_strobe_low got %b required 0", bus16.strobe);
        end
        n = 0;
        while (done16 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done16 !== 1'b1 || pass16 !== 1'b1 || err16 !== 16'd0) begin
            errors++;
            $display("FAIL seed0_result done=%b pass=%b err=%0d required done=1 pass=1 err=0",
                     done16, pass16, err16);
        end
    endtask

    task automatic test_timing_mid_start();
        int n;
        pulse16();
        checks++;
        if (busy16 !== 1'b1 || done16 !== 1'b0) begin
            errors++;
            $display("FAIL t16_start busy=%b done=%b required busy=1 done=0", busy16, done16);
        end
        n = 0;
        while (done16 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            start16 = (n == 20);
        end
        start16 = 1'b0;
        checks++;
        if (n != 64 || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL t16_done_cycles got %0d busy=%b required 64 busy=0", n, busy16);
        end
        checks++;
        if (pass16 !== 1'b1 || err16 !== 16'd0 || st16 !== ST_DONE) begin
            errors++;
            $display("FAIL t16_result pass=%b err=%0d state=%0d required pass=1 err=0 state=%0d",
                     pass16, err16, st16, ST_DONE);
        end
    endtask

    task automatic test_pass_run();
        int cyc;
        run_main(0, cyc);
        checks++;
        if (cyc != 1024) begin
            errors++;
            $display("FAIL main_done_cycles got %0d required 1024", cyc);
        end
        checks++;
        if (pass_m !== 1'b1 || err_m !== 16'd0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL main_pass pass=%b err=%0d busy=%b required pass=1 err=0 busy=0",
                     pass_m, err_m, busy_m);
        end
        // done holds while idle
        repeat (5) @(negedge clk);
        checks++;
        if (done_m !== 1'b1 || st_m !== ST_DONE) begin
            errors++;
            $display("FAIL main_done_hold done=%b state=%0d required done=1 state=%0d",
                     done_m, st_m, ST_DONE);
        end
`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
        checks++;
        if (ffv_m !== 1'b0) begin
            errors++;
            $display("FAIL main_ff_clear got %b required 0", ffv_m);
        end
`endif
    endtask

    task automatic test_stuck_z0();
        int cyc;
        run_main(1, cyc);
        checks++;
        if (cyc != 1024 || pass_m !== 1'b0) begin
            errors++;
            $display("FAIL stuck_pass cycles=%0d pass=%b required 1024 pass=0", cyc, pass_m);
        end
        checks++;
        if (int'(err_m) != odd_cnt) begin
            errors++;
            $display("FAIL stuck_err_count got %0d required %0d", err_m, odd_cnt);
        end
`ifdef MUL9X9_CHECKER_FIRST_FAIL_EN
        checks++;
        if (ffv_m !== 1'b1 || ffz_m !== {ffe_m[17:1], 1'b0} || ffe_m[0] !== 1'b1) begin
            errors++;
            $display("FAIL stuck_first_fail valid=%b z=%h exp=%h", ffv_m, ffz_m, ffe_m);
        end
`endif
    endtask

    task automatic test_rst_priority();
        int cyc;
        run_main(2, cyc);
        checks++;
        if (int'(err_m) != diff_cnt) begin
            errors++;
            $display("FAIL rstprio_err_count got %0d required %0d", err_m, diff_cnt);
        end
        checks++;
        if (pass_m !== (diff_cnt == 0)) begin
            errors++;
            $display("FAIL rstprio_pass got %b required %b", pass_m, (diff_cnt == 0));
        end
    endtask

    task automatic test_midrun_reset();
        int cyc;
        fault_mode = 0;
        pulse_main();
        repeat (100) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy_m, done_m, pass_m, err_m, bus_m.strobe, bus_m.cea, bus_m.ceb, bus_m.rsta,
             bus_m.rstb, bus_m.a_signed, bus_m.b_signed, bus_m.a, bus_m.b} !== 44'd0) begin
            errors++;
            $display("FAIL midrst_outputs busy=%b done=%b err=%0d a=%h b=%h required all 0",
                     busy_m, done_m, err_m, bus_m.a, bus_m.b);
        end
        @(negedge clk);
        checks++;
        if (st_m !== ST_IDLE || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got %0d busy=%b required %0d busy=0", st_m, busy_m, ST_IDLE);
        end
        rstn = 1'b1;
        @(negedge clk);
        run_main(0, cyc);
        checks++;
        if (cyc != 1024 || pass_m !== 1'b1 || err_m !== 16'd0) begin
            errors++;
            $display("FAIL midrst_rerun cycles=%0d pass=%b err=%0d required 1024 pass=1 err=0",
                     cyc, pass_m, err_m);
        end
    endtask

    initial begin
        test_reset();
        test_ref_products();
        test_seed_zero();
        test_timing_mid_start();
        test_pass_run();
        test_stuck_z0();
        test_rst_priority();
        test_pass_run();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
